// File: rtl/ppu_counter_pkg.sv
// Shared widths and axis payload type for the PPU raster/scroll counter.
package ppu_counter_pkg;

  localparam int unsigned COARSE_W_DEF = 9;
  localparam int unsigned FINE_W_DEF   = 3;

  typedef struct packed {
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
  } axis_state_t;

endpackage

// File: rtl/ppu_axis_counter.sv
// One raster axis: stored terminal coarse value, {coarse, fine} counter and
// registered wrap pulse. The wrap target comes from the parent (skip support).
module ppu_axis_counter
  import ppu_counter_pkg::*;
#(
  parameter  int unsigned COARSE_W = COARSE_W_DEF,
  parameter  int unsigned FINE_W   = FINE_W_DEF,
  localparam int unsigned AW       = COARSE_W + FINE_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                load,
  input  logic                en,
  input  logic [COARSE_W-1:0] init,
  input  logic [COARSE_W-1:0] max,
  input  logic [AW-1:0]       wrap_val,
  output logic [AW-1:0]       counter,
  output logic                wrap,
  output logic                at_term_c
);

  logic [COARSE_W-1:0] max_q;

  // Full-scale check catches counters loaded above the programmed terminal.
  assign at_term_c = (counter == {max_q, {FINE_W{1'b1}}}) || (&counter);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      counter <= '0;
      max_q   <= '1;
      wrap    <= 1'b0;
    end else if (load) begin
      counter <= {init, FINE_W'(0)};
      max_q   <= max;
      wrap    <= 1'b0;
    end else if (en && at_term_c) begin
      counter <= wrap_val;
      wrap    <= 1'b1;
    end else if (en) begin
      counter <= counter + AW'(1);
      wrap    <= 1'b0;
    end else begin
      wrap    <= 1'b0;
    end
  end

endmodule

// File: rtl/ppu_raster_counter.sv
// Two-axis raster counter: X every cycle, Y once per X wrap, with line/frame
// strobes. Define PPU_COUNTER_SKIP_EN for frame parity and odd-frame dot skip.
module ppu_raster_counter
  import ppu_counter_pkg::*;
#(
  parameter  int unsigned COARSE_W = COARSE_W_DEF,
  parameter  int unsigned FINE_W   = FINE_W_DEF,
  localparam int unsigned AW       = COARSE_W + FINE_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                load,
  input  logic                halt,
  input  logic [COARSE_W-1:0] init_x,
  input  logic [COARSE_W-1:0] init_y,
  input  logic [COARSE_W-1:0] max_x,
  input  logic [COARSE_W-1:0] max_y,
  output logic [AW-1:0]       counter_x,
  output logic [AW-1:0]       counter_y,
  output logic                wrap_x,
  output logic                wrap_y,
  output logic                frame_odd
);

  logic          x_term_c;
  logic          y_term_c;
  logic          en_x_c;
  logic          en_y_c;
  logic [AW-1:0] x_wrap_val_c;

  assign en_x_c = ~halt;
  assign en_y_c = ~halt & x_term_c;

`ifdef PPU_COUNTER_SKIP_EN
  logic frame_wrap_c;
  logic frame_odd_q;

  assign frame_wrap_c = ~load & en_y_c & y_term_c;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_odd_q <= 1'b0;
    end else if (frame_wrap_c) begin
      frame_odd_q <= ~frame_odd_q;
    end
  end

  // Entering an odd frame starts the line at dot 1.
  assign x_wrap_val_c = (frame_wrap_c && !frame_odd_q) ? AW'(1) : AW'(0);
  assign frame_odd    = frame_odd_q;
`else
  logic unused_y_term;

  assign unused_y_term = y_term_c;
  assign x_wrap_val_c  = AW'(0);
  assign frame_odd     = 1'b0;
`endif

  ppu_axis_counter #(
    .COARSE_W (COARSE_W),
    .FINE_W   (FINE_W)
  ) u_axis_x (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load),
    .en        (en_x_c),
    .init      (init_x),
    .max       (max_x),
    .wrap_val  (x_wrap_val_c),
    .counter   (counter_x),
    .wrap      (wrap_x),
    .at_term_c (x_term_c)
  );

  ppu_axis_counter #(
    .COARSE_W (COARSE_W),
    .FINE_W   (FINE_W)
  ) u_axis_y (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load),
    .en        (en_y_c),
    .init      (init_y),
    .max       (max_y),
    .wrap_val  (AW'(0)),
    .counter   (counter_y),
    .wrap      (wrap_y),
    .at_term_c (y_term_c)
  );

endmodule

// File: doc/ppu_raster_counter.md
# ppu_raster_counter

Parametrised two-axis raster/scroll counter for the PPU pipeline. Each axis is a {coarse, fine} counter with a programmable terminal value. The X axis advances every cycle unless halted. The Y axis advances once per X wrap. The block emits registered wrap pulses that the fetch and render stages use as line-end and frame-end strobes, and optionally tracks frame parity to drop the first dot of odd frames.

## Interface
Parameters:
- COARSE_W, 9, coarse (tile/line) field width per axis.
- FINE_W, 3, fine (pixel) field width per axis; axis width AW = COARSE_W+FINE_W.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- load  in  1  load init and max values into both axes.
- halt  in  1  freeze both axes and all state.
- init_x, init_y  in  COARSE_W  coarse start values; fine starts at 0.
- max_x, max_y  in  COARSE_W  coarse terminal values, latched on load.
- counter_x, counter_y  out  AW  current {coarse, fine} positions.
- wrap_x  out  1  one-cycle pulse: X just wrapped (line end).
- wrap_y  out  1  one-cycle pulse: Y just wrapped (frame end).
- frame_odd  out  1  frame parity; constant 0 without PPU_COUNTER_SKIP_EN.

## Operation
- Terminal value per axis: T = {max_stored, FINE_W'all-ones}.
  - An axis wraps when counter == T, or when counter == all-ones (full scale). This covers init > max.
- Priority per edge: load > halt > count.
- load: counter_x <= {init_x, 0}, counter_y <= {init_y, 0}, max_x/max_y stored, wrap_x = wrap_y = 0.
  - frame_odd is unchanged.
  - Takes effect even if halt = 1.
- halt (no load): every register holds; wrap_x/wrap_y forced 0.
- count, X axis:
  - If X is not at its terminal value: counter_x + 1.
  - Else: counter_x <= 0, wrap_x <= 1.
- count, Y axis: changes only on an edge where X wraps.
  - If Y is not at its terminal value: counter_y + 1.
  - Else: counter_y <= 0, wrap_y <= 1, and frame_odd toggles.
- wrap_x and wrap_y are 0 on every edge not listed above.
- Arithmetic is modulo 2^AW. There is never a carry between axes other than the wrap rule above.

## Timing
- Reset: counter_x = counter_y = 0, wrap_x = wrap_y = 0, frame_odd = 0, stored max = all-ones. Reset is asynchronous on assert and leaves RESET deasserted synchronously to CLK.
- Latency: load is visible on outputs one cycle after the edge that samples it.
- wrap_x is high in the same cycle counter_x first shows 0 (or 1 when skipping). wrap_y coincides with that wrap_x.
- X period = (max_x+1)·2^FINE_W cycles when init_x ≤ max_x.
- Simultaneous load with a terminal value: load wins; no wrap pulse.
- RESET mid-count returns all outputs to reset values immediately, including clearing a pulse in flight.
- A halted wrap is not lost: the wrap completes on the first unhalted edge.

## Configuration
- PPU_COUNTER_SKIP_EN defined:
  - On the Y-wrap edge that sets frame_odd 0→1, counter_x <= 1 instead of 0, dropping dot 0 of odd frames.
  - All other wraps go to 0.
- Not defined: the frame_odd register is removed, the port is tied 0, and the X wrap always goes to 0.

## Structure
- Package ppu_counter_pkg holds: default COARSE_W/FINE_W localparams, and a typedef for an axis state struct {coarse, fine}.
- Sub-module ppu_axis_counter holds one axis: stored max, terminal compare, increment/wrap, registered wrap pulse, and an enable input.
  - Instantiate it twice. The Y enable is the X terminal-and-count condition.
- Top level holds load/halt priority, frame_odd and the skip mux.

## Test plan
- Reset then free-run, load max_x=2, max_y=1, init 0: wrap_x every 24 cycles; counter_y 0→1→…→15→0 with wrap_y after 384 cycles; frame_odd toggles.
- halt asserted while counter_x=23 (terminal) for 5 cycles: counter_x holds 23, no wrap_x; wrap_x fires on the first cycle after release.
- load with init_x=5 while counting: next cycle counter_x=40, wrap pulses 0, frame_odd unchanged. load and halt together: load still applied.
- init_x=7, max_x=2: counts 56…4095, then wraps to 0 with wrap_x.
- With PPU_COUNTER_SKIP_EN, max_x=max_y=0: the first frame wrap gives counter_x=1 and frame_odd=1; the next frame wrap gives counter_x=0 and frame_odd=0. Without the macro, frame_odd stays 0.
- RESET asserted asynchronously mid-cycle during a wrap_y pulse: all outputs go to 0 before the next edge; stored max returns to all-ones.
